// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, state encoding and lane helper for the systolic array front end
package systolic_pkg;

  localparam int SYS_N     = 32;
  localparam int SYS_K     = 4;
  localparam int SYS_DEPTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOAD   = 2'd0;
  localparam state_t ST_FULL   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_tile_buffer.sv
// rtl/skew_tile_buffer.sv - DEPTH x (K*N) tile store, one write port, one read port per lane
module skew_tile_buffer
  import systolic_pkg::*;
#(
  parameter int N     = SYS_N,
  parameter int K     = SYS_K,
  parameter int DEPTH = SYS_DEPTH,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [K*N-1:0]  wdata,
  input  logic [K*AW-1:0] raddr,
  output logic [K*N-1:0]  rdata
);

  logic [K*N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Each lane reads only its own slice, from its own (skewed) row.
  for (genvar i = 0; i < K; i++) begin : g_rd
    assign rdata[lane_lo(i, N) +: N] = mem_q[raddr[i*AW +: AW]][lane_lo(i, N) +: N];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - tile buffer and diagonal skewer feeding one edge of the PE grid
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N     = SYS_N,
  parameter int K     = SYS_K,
  parameter int DEPTH = SYS_DEPTH
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*N-1:0] in_data,
  input  logic           start,
  output logic [K*N-1:0] out_data,
  output logic [K-1:0]   out_valid,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH + K);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [TW-1:0]  t_q, t_d;
  logic [K*N-1:0] data_q, data_d;
  logic [K-1:0]   valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           hs, streaming, last_step;
  logic [CW-1:0]  c_eff, c_cur;
  logic [TW-1:0]  t_cur;
  logic [AW-1:0]  waddr;
  logic [K*AW-1:0] raddr;
  logic [K*N-1:0] rdata, step_data;
  logic [K-1:0]   step_valid;

  assign in_ready  = (state_q == ST_LOAD) && (count_q < CW'(DEPTH));
  assign hs        = in_valid && in_ready;
  assign c_eff     = count_q + CW'(hs);
  assign streaming = (state_q == ST_STREAM);
  assign c_cur     = streaming ? count_q : c_eff;
  assign t_cur     = streaming ? t_q : '0;
  assign last_step = streaming && (t_q == TW'(count_q) + TW'(K - 1));
  assign waddr     = AW'(count_q);

  skew_tile_buffer #(.N(N), .K(K), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (hs),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // A vector written on the start edge is not yet in the store, so forward it.
  for (genvar i = 0; i < K; i++) begin : g_lane
    logic [TW:0] diff;
    logic        byp;
    assign diff          = {1'b0, t_cur} - (TW + 1)'(i);
    assign step_valid[i] = !diff[TW] && (diff[TW-1:0] < TW'(c_cur));
    assign raddr[i*AW +: AW] = step_valid[i] ? AW'(diff[TW-1:0]) : '0;
    assign byp           = hs && (raddr[i*AW +: AW] == waddr);
    assign step_data[lane_lo(i, N) +: N] = !step_valid[i] ? '0 :
                                           byp ? in_data[lane_lo(i, N) +: N] :
                                                 rdata[lane_lo(i, N) +: N];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    t_d     = t_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (streaming) begin
      if (last_step) begin
        state_d = ST_LOAD;
        count_d = '0;
        t_d     = '0;
        data_d  = '0;
        valid_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        data_d  = step_data;
        valid_d = step_valid;
        t_d     = t_q + TW'(1);
      end
    end else begin
      if (hs) begin
        count_d = c_eff;
        if (c_eff == CW'(DEPTH)) begin
          state_d = ST_FULL;
        end
      end
      if (start && (c_eff != '0)) begin
        state_d = ST_STREAM;
        count_d = c_eff;
        t_d     = TW'(1);
        data_d  = step_data;
        valid_d = step_valid;
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      t_q     <= '0;
      data_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      t_q     <= t_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

  localparam int N     = 32;
  localparam int K     = 4;
  localparam int DEPTH = 4;

  logic           clk;
  logic           clr;
  logic           in_valid;
  logic           in_ready;
  logic [K*N-1:0] in_data;
  logic           start;
  logic [K*N-1:0] out_data;
  logic [K-1:0]   out_valid;
  logic           busy;
  logic           done;

  int n_vec = 0;
  int n_bad = 0;
  int ld_n  = 0;

  logic [K*N-1:0] exp_vec [DEPTH];
  logic [N-1:0]   obs_l0  [16];
  logic [N-1:0]   obs_l3  [16];

  systolic_skew_feeder #(.N(N), .K(K), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .start     (start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [K*N-1:0] got, input logic [K*N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [K*N-1:0] mk(input int base, input int j);
    logic [K*N-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++) v[i*N +: N] = N'(base + 16 * j + i);
    return v;
  endfunction

  task automatic push(input logic [K*N-1:0] v);
    chk("in_ready_load", {127'b0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = v;
    exp_vec[ld_n] = v;
    ld_n++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_tile(input int base, input int n);
    ld_n = 0;
    for (int j = 0; j < n; j++) push(mk(base, j));
  endtask

  // Pulses start, then checks every step against the diagonal model.
  task automatic run_stream(input int c, input int poke);
    int l;
    int busy_cnt;
    logic [K*N-1:0] ed;
    logic [K-1:0]   ev;
    l = c + K - 1;
    busy_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    for (int t = 0; t < l; t++) begin
      ed = '0;
      ev = '0;
      for (int i = 0; i < K; i++) begin
        if (t - i >= 0 && t - i < c) begin
          ed[i*N +: N] = exp_vec[t - i][i*N +: N];
          ev[i] = 1'b1;
        end
      end
      chk($sformatf("data_t%0d", t), out_data, ed);
      chk($sformatf("valid_t%0d", t), {124'b0, out_valid}, {124'b0, ev});
      chk("ready_stream", {127'b0, in_ready}, 128'd0);
      chk("done_stream", {127'b0, done}, 128'd0);
      obs_l0[t] = out_data[0 +: N];
      obs_l3[t] = out_data[3*N +: N];
      if (busy) busy_cnt++;
      if (t == poke) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("busy_len", 128'(busy_cnt), 128'(l));
    chk("done_pulse", {127'b0, done}, 128'd1);
    chk("busy_end", {127'b0, busy}, 128'd0);
    chk("data_end", out_data, '0);
    chk("valid_end", {124'b0, out_valid}, 128'd0);
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_data", out_data, '0);
    chk("rst_valid", {124'b0, out_valid}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    chk("rst_ready", {127'b0, in_ready}, 128'd1);

    // Full tile plus a refused fifth vector and an ignored mid-stream start.
    load_tile(0, 4);
    chk("full_ready", {127'b0, in_ready}, 128'd0);
    in_valid = 1'b1;
    in_data  = {4{32'hDEAD_BEEF}};
    tick();
    in_valid = 1'b0;
    chk("full_ready2", {127'b0, in_ready}, 128'd0);
    run_stream(4, 2);
    chk("l0_s0", 128'(obs_l0[0]), 128'd0);
    chk("l0_s1", 128'(obs_l0[1]), 128'd16);
    chk("l0_s2", 128'(obs_l0[2]), 128'd32);
    chk("l0_s3", 128'(obs_l0[3]), 128'd48);
    chk("l3_s3", 128'(obs_l3[3]), 128'd3);
    chk("l3_s4", 128'(obs_l3[4]), 128'd19);
    chk("l3_s5", 128'(obs_l3[5]), 128'd35);
    chk("l3_s6", 128'(obs_l3[6]), 128'd51);
    chk("l0_s4_zero", 128'(obs_l0[4]), 128'd0);
    chk("l3_s2_zero", 128'(obs_l3[2]), 128'd0);
    tick();
    chk("done_low", {127'b0, done}, 128'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start0_busy", {127'b0, busy}, 128'd0);
    chk("start0_valid", {124'b0, out_valid}, 128'd0);
    chk("start0_ready", {127'b0, in_ready}, 128'd1);

    // Partial tile.
    load_tile(32'h100, 2);
    chk("part_ready", {127'b0, in_ready}, 128'd1);
    run_stream(2, -1);
    tick();

    // Start with a same-cycle handshake after one vector.
    load_tile(32'h200, 1);
    exp_vec[ld_n] = mk(32'h200, 1);
    ld_n++;
    in_valid = 1'b1;
    in_data  = mk(32'h200, 1);
    run_stream(2, -1);
    chk("sc_l0_s1", 128'(obs_l0[1]), 128'h210);
    tick();

    // Same-cycle handshake from empty: single-vector tile.
    ld_n = 0;
    exp_vec[0] = mk(32'h300, 0);
    ld_n = 1;
    in_valid = 1'b1;
    in_data  = mk(32'h300, 0);
    run_stream(1, -1);
    chk("c1_l0_s0", 128'(obs_l0[0]), 128'h300);
    chk("c1_l3_s3", 128'(obs_l3[3]), 128'h303);
    tick();

    // Reset mid-stream.
    load_tile(0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_clr_busy", {127'b0, busy}, 128'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_data", out_data, '0);
    chk("clr_valid", {124'b0, out_valid}, 128'd0);
    chk("clr_busy", {127'b0, busy}, 128'd0);
    chk("clr_done", {127'b0, done}, 128'd0);
    chk("clr_ready", {127'b0, in_ready}, 128'd1);

    load_tile(32'h400, 3);
    run_stream(3, -1);

    // Back-to-back: next tile loads beginning in the done cycle.
    chk("b2b_done", {127'b0, done}, 128'd1);
    load_tile(32'h500, 4);
    run_stream(4, -1);
    chk("b2b_l0_s0", 128'(obs_l0[0]), 128'h500);
    chk("b2b_l3_s6", 128'(obs_l3[6]), 128'h533);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Tile buffer and diagonal skewer in front of the Processing_Element grid. It accepts up to DEPTH K-lane operand vectors, one per handshake, and holds them until a start pulse. It then replays them so that lane i lags lane 0 by exactly i cycles, producing the diagonal wavefront the systolic array needs on its west (A) or north (B) edge. Idle lanes are driven with zero.

## Interface
Parameters:
- N, 32, operand width per lane (matches PE width)
- K, 4, number of lanes (array rows or columns)
- DEPTH, 4, maximum vectors per tile (≥1)

Ports:
- clk  in  1  single clock; all logic on posedge
- clr  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data holds a valid vector
- in_ready  out  1  block can accept a vector this cycle
- in_data  in  K*N  one vector; lane i at bits [i*N +: N]
- start  in  1  single-cycle request to stream the buffered tile
- out_data  out  K*N  skewed stream; lane i at bits [i*N +: N]
- out_valid  out  K  per-lane valid for out_data
- busy  out  1  high from the start edge until done
- done  out  1  one-cycle pulse at end of stream

## Operation
- States: LOAD, FULL, STREAM.
- Reset (clr=1 at an edge), from any state including mid-stream:
  - state=LOAD, count=0, t=0.
  - out_data=0, out_valid=0, busy=0, done=0.
  - Buffer contents are don't-care.
- LOAD:
  - in_ready = (count < DEPTH).
  - A handshake (in_valid & in_ready) writes buf[count] and increments count.
  - When count reaches DEPTH, go to FULL.
- FULL: in_ready=0. in_valid is ignored.
- start in LOAD or FULL with effective count C ≥ 1 enters STREAM with stream length L = C + K − 1.
  - In LOAD, a same-cycle handshake is accepted and counted, so C = count + 1.
- start with effective count 0 is ignored.
- start while in STREAM is ignored.
- STREAM, step t = 0 .. L−1, lane i:
  - If 0 ≤ t−i < C: out_data lane i = buf[t−i] and out_valid[i]=1.
  - Otherwise: lane i = 0 and out_valid[i]=0.
- After step L−1:
  - out_data=0, out_valid=0.
  - done=1 for one cycle; busy=0.
  - count=0; state=LOAD.
- in_ready=0 throughout STREAM. The next tile can load starting in the done cycle.
- Buffered data is passed bit-exact. No arithmetic is applied to data. Only counters do arithmetic:
  - count: clog2(DEPTH+1) bits.
  - t: clog2(DEPTH+K) bits.

## Timing
- All outputs are registered. in_ready is the only combinational output; it is a function of state and count only.
- Edge e0 samples start. At e0, outputs for step t=0 are loaded and busy rises. Lane 0 data for buf[0] is therefore visible in the cycle after e0.
- Step t is visible in the cycle after edge e0+t.
- Edge e0+L clears the outputs and raises done. Edge e0+L+1 lowers done.
- busy is high in cycles e0 .. e0+L−1, i.e. for exactly L cycles.
- Load throughput: one vector per cycle.
- Minimum start-to-start spacing is L+1 cycles, plus the load time of the next tile.

## Structure
- Shared package (systolic_pkg):
  - state enum {LOAD, FULL, STREAM}.
  - Lane-slice helper constant/function for i*N offsets.
  - Default N, K, DEPTH values, shared with the array top.
- One sub-module, skew_tile_buffer: a DEPTH×(K*N) register file with one write port and K independent read ports (lane i reads index t−i).
- FSM, counters and output registers stay in systolic_skew_feeder.

## Test plan
- Full tile, N=32, K=4, DEPTH=4, vectors v0..v3 with lane i of vj = 16*j + i:
  - Start gives L=7.
  - Lane 0 carries 0,16,32,48 over steps 0..3.
  - Lane 3 carries 3,19,35,51 over steps 3..6.
  - Invalid steps output 0 with out_valid low.
  - done pulses 7 cycles after the start edge.
- Partial tile, 2 vectors loaded then start:
  - L=5; lanes are valid only for t−i ∈ {0,1}.
  - busy lasts exactly 5 cycles.
- Start with a same-cycle handshake in LOAD after 1 vector:
  - C=2; the new vector appears as buf[1] on lane 0 at step 1.
- Back-pressure:
  - A 5th in_valid after 4 accepted vectors sees in_ready=0; the data is not stored.
  - start in STREAM and start with count 0 produce no change.
- Reset mid-stream:
  - clr at step 3 zeroes all outputs on the next cycle; state is LOAD with count 0.
  - A fresh tile then streams correctly.
- Back-to-back:
  - A second tile is loaded starting in the done cycle and streamed.
  - No stale data from the first tile appears on any lane.
